// File: rtl/peripheral_control.sv
// Memory-mapped peripheral block: reloadable timer with interrupt, LED/7-segment
// registers, synchronized switches and a free-running cycle counter.
module peripheral_control #(
    parameter logic [31:0] BASE = 32'h4000_0000,
    parameter int unsigned SW_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            peri_cre,
    input  logic            peri_cwe,
    input  logic [31:0]     peri_addr,
    input  logic [31:0]     peri_wdata,
    output logic [31:0]     peri_rdata,
    input  logic [SW_W-1:0] switch,
    output logic [SW_W-1:0] led,
    output logic [11:0]     digi,
    output logic            irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGI_W = 12;
    localparam int unsigned TCON_W = 3;

    localparam logic [DATA_W-1:0] ADDR_TH      = BASE + 32'h00;
    localparam logic [DATA_W-1:0] ADDR_TL      = BASE + 32'h04;
    localparam logic [DATA_W-1:0] ADDR_TCON    = BASE + 32'h08;
    localparam logic [DATA_W-1:0] ADDR_LED     = BASE + 32'h0C;
    localparam logic [DATA_W-1:0] ADDR_SWITCH  = BASE + 32'h10;
    localparam logic [DATA_W-1:0] ADDR_DIGI    = BASE + 32'h14;
    localparam logic [DATA_W-1:0] ADDR_SYSTICK = BASE + 32'h18;

    logic [DATA_W-1:0] th_q, th_d;
    logic [DATA_W-1:0] tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic [SW_W-1:0]   led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [DATA_W-1:0] systick_q, systick_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]   sw_sync_q, sw_sync_d;

    logic sel_th, sel_tl, sel_tcon, sel_led, sel_switch, sel_digi, sel_systick;
    logic we_th, we_tl, we_tcon, we_led, we_digi;
    logic tl_max, irq_set;

    // Full 32-bit address decode; misaligned or unlisted addresses select nothing
    always_comb begin
        sel_th      = (peri_addr == ADDR_TH);
        sel_tl      = (peri_addr == ADDR_TL);
        sel_tcon    = (peri_addr == ADDR_TCON);
        sel_led     = (peri_addr == ADDR_LED);
        sel_switch  = (peri_addr == ADDR_SWITCH);
        sel_digi    = (peri_addr == ADDR_DIGI);
        sel_systick = (peri_addr == ADDR_SYSTICK);
        we_th       = peri_cwe & sel_th;
        we_tl       = peri_cwe & sel_tl;
        we_tcon     = peri_cwe & sel_tcon;
        we_led      = peri_cwe & sel_led;
        we_digi     = peri_cwe & sel_digi;
    end

    // Same-cycle read of pre-edge register state
    always_comb begin
        peri_rdata = '0;
        if (peri_cre) begin
            if (sel_th)           peri_rdata = th_q;
            else if (sel_tl)      peri_rdata = tl_q;
            else if (sel_tcon)    peri_rdata = DATA_W'(tcon_q);
            else if (sel_led)     peri_rdata = DATA_W'(led_q);
            else if (sel_switch)  peri_rdata = DATA_W'(sw_sync_q);
            else if (sel_digi)    peri_rdata = DATA_W'(digi_q);
            else if (sel_systick) peri_rdata = systick_q;
        end
    end

    // Timer and register next state; CPU writes override counting, status set beats a clear
    always_comb begin
        tl_max    = (tl_q == '1);
        irq_set   = tcon_q[0] & tl_max & tcon_q[1];
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + DATA_W'(1);
        sw_meta_d = switch;
        sw_sync_d = sw_meta_q;

        if (tcon_q[0]) begin
            tl_d = tl_max ? th_q : tl_q + DATA_W'(1);
        end
        if (we_th)   th_d   = peri_wdata;
        if (we_tl)   tl_d   = peri_wdata;
        if (we_tcon) tcon_d = peri_wdata[TCON_W-1:0];
        if (we_led)  led_d  = peri_wdata[SW_W-1:0];
        if (we_digi) digi_d = peri_wdata[DIGI_W-1:0];
        tcon_d[2] = tcon_d[2] | irq_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = tcon_q[2];

endmodule

// File: tb/tb_peripheral_control.sv
// Self-checking bench for peripheral_control: directed vector table, hand
// sequences for reset/switch corners, and randomized traffic against a reference model.
module tb_peripheral_control;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TICK = BASE + 32'h18;

    logic        clk;
    logic        rst;
    logic        peri_cre;
    logic        peri_cwe;
    logic [31:0] peri_addr;
    logic [31:0] peri_wdata;
    logic [31:0] peri_rdata;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    peripheral_control #(.BASE(BASE), .SW_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .peri_cre   (peri_cre),
        .peri_cwe   (peri_cwe),
        .peri_addr  (peri_addr),
        .peri_wdata (peri_wdata),
        .peri_rdata (peri_rdata),
        .switch     (switch),
        .led        (led),
        .digi       (digi),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: registers as plain variables, switch pipeline as a queue
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic [7:0]  m_swq[$];

    function automatic int moff(input logic [31:0] a);
        logic [31:0] off;
        if (a[1:0] != 2'b00) return -1;
        if (a < BASE) return -1;
        off = a - BASE;
        if (off > 32'd24) return -1;
        return int'(off / 4);
    endfunction

    function automatic logic [31:0] mread(input logic cre, input logic [31:0] a);
        if (!cre) return 32'h0;
        case (moff(a))
            0: return m_th;
            1: return m_tl;
            2: return {29'h0, m_tcon};
            3: return {24'h0, m_led};
            4: return (m_swq.size() == 2) ? {24'h0, m_swq[0]} : 32'h0;
            5: return {20'h0, m_digi};
            6: return m_tick;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tick = 0; m_tcon = 0; m_led = 0; m_digi = 0;
        m_swq.delete();
    endtask

    task automatic model_step();
        logic [31:0] next_tl;
        logic        set;
        next_tl = m_tl;
        set     = 1'b0;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                next_tl = m_th;
                set     = m_tcon[1];
            end else begin
                next_tl = m_tl + 1;
            end
        end
        if (peri_cwe) begin
            case (moff(peri_addr))
                0: m_th   = peri_wdata;
                1: next_tl = peri_wdata;
                2: m_tcon = peri_wdata[2:0];
                3: m_led  = peri_wdata[7:0];
                5: m_digi = peri_wdata[11:0];
                default: ;
            endcase
        end
        if (set) m_tcon[2] = 1'b1;
        m_tl   = next_tl;
        m_tick = m_tick + 1;
        m_swq.push_back(switch);
        if (m_swq.size() > 2) void'(m_swq.pop_front());
    endtask

    // One bus cycle: drive, sample the combinational read, clock, advance the model
    task automatic cyc(input logic cre, input logic cwe, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic [31:0] exp_rd);
        peri_cre   = cre;
        peri_cwe   = cwe;
        peri_addr  = addr;
        peri_wdata = wdata;
        #1;
        rd     = peri_rdata;
        exp_rd = mread(cre, addr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        cre;
        logic        cwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        irq;
        logic [7:0]  led;
        logic [11:0] digi;
    } vec_t;

    function automatic vec_t v(input logic cre, input logic cwe, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd,
                               input logic irq_e, input logic [7:0] led_e, input logic [11:0] digi_e);
        vec_t r;
        r.cre = cre; r.cwe = cwe; r.addr = addr; r.wdata = wdata;
        r.rd = rd; r.irq = irq_e; r.led = led_e; r.digi = digi_e;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [31:0] rd, erd;
        logic [31:0] addrs[7];
        checks   = 0;
        failures = 0;
        rst = 1'b0; peri_cre = 1'b0; peri_cwe = 1'b0;
        peri_addr = '0; peri_wdata = '0; switch = '0;
        model_reset();

        addrs = '{A_TH, A_TL, A_TCON, A_LED, A_SW, A_DIGI, A_TICK};
        foreach (addrs[k]) begin
            peri_cre  = 1'b1;
            peri_addr = addrs[k];
            #1;
            chk($sformatf("reset_read_%0d", k), peri_rdata, 32'h0);
        end
        chk("reset_led", {24'h0, led}, 32'h0);
        chk("reset_digi", {20'h0, digi}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        peri_cre = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, A_TICK, 32'h0, rd, erd);
        cyc(1'b1, 1'b0, A_TICK, 32'h0, rd, erd);
        chk("systick_after_3", rd, 32'h3);

        // Timer reload/irq, simultaneous writes, LED/DIGI and ignored writes
        tbl.push_back(v(0, 1, A_TH,   32'hFFFF_FFFC, 32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TL,   32'hFFFF_FFFE, 32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TCON, 32'h3,         32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFE, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFF, 1, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFC, 1, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TCON, 32'h0,         32'h7,         1, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TCON, 32'h3,         32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(1, 1, A_TCON, 32'h3,         32'h3,         1, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TCON, 32'h0,         32'h7,         1, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TL,   32'h5,         32'h0,         1, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'h5,         1, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'h6,         1, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TCON, 32'h0,         32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TL,   32'hFFFF_FFFE, 32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TCON, 32'h1,         32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFE, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFF, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TCON, 32'h0,         32'h1,         0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFD, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFE, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 1, A_TH,   32'h10,        32'hFFFF_FFFC, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFC, 0, 8'h00, 12'h000));
        tbl.push_back(v(1, 0, A_TH,   32'h0,         32'h10,        0, 8'h00, 12'h000));
        tbl.push_back(v(0, 1, A_TCON, 32'h0,         32'h0,         0, 8'h00, 12'h000));
        tbl.push_back(v(1, 1, A_LED,  32'hA5,        32'h0,         0, 8'hA5, 12'h000));
        tbl.push_back(v(1, 1, A_DIGI, 32'hE3F,       32'h0,         0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_LED,  32'h0,         32'hA5,        0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_DIGI, 32'h0,         32'hE3F,       0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 1, A_SW,   32'hFFFF_FFFF, 32'h0,         0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 1, BASE + 32'h1C, 32'hFFFF_FFFF, 32'h0,  0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 1, BASE + 32'h41, 32'hFFFF_FFFF, 32'h0,  0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 1, BASE + 32'h0D, 32'hFF,   32'h0,       0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 1, BASE + 32'h100C, 32'h0,  32'h0,       0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_LED,  32'h0,         32'hA5,        0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_TL,   32'h0,         32'hFFFF_FFFF, 0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_TH,   32'h0,         32'h10,        0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_TCON, 32'h0,         32'h0,         0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_DIGI, 32'h0,         32'hE3F,       0, 8'hA5, 12'hE3F));
        tbl.push_back(v(1, 0, A_SW,   32'h0,         32'h0,         0, 8'hA5, 12'hE3F));
        tbl.push_back(v(0, 0, A_LED,  32'h0,         32'h0,         0, 8'hA5, 12'hE3F));

        foreach (tbl[i]) begin
            cyc(tbl[i].cre, tbl[i].cwe, tbl[i].addr, tbl[i].wdata, rd, erd);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
            chk($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, tbl[i].led});
            chk($sformatf("vec%0d_digi", i), {20'h0, digi}, {20'h0, tbl[i].digi});
        end

        // Switch synchronizer: visible only after the second edge
        switch = 8'h3C;
        cyc(1'b1, 1'b0, A_SW, 32'h0, rd, erd);
        chk("switch_edge0", rd, 32'h0);
        cyc(1'b1, 1'b0, A_SW, 32'h0, rd, erd);
        chk("switch_edge1", rd, 32'h0);
        cyc(1'b1, 1'b0, A_SW, 32'h0, rd, erd);
        chk("switch_edge2", rd, 32'h3C);

        // Randomized traffic against the model, with one asynchronous reset mid-run
        for (int i = 0; i < 600; i++) begin
            logic        cre, cwe;
            logic [31:0] a, w;
            int          pick;
            if (i == 300) begin
                #2;
                rst = 1'b0;
                peri_cre = 1'b1; peri_cwe = 1'b0; peri_addr = A_LED;
                #1;
                chk("async_rst_rdata", peri_rdata, 32'h0);
                chk("async_rst_led", {24'h0, led}, 32'h0);
                chk("async_rst_digi", {20'h0, digi}, 32'h0);
                chk("async_rst_irq", {31'h0, irq}, 32'h0);
                peri_addr = A_TICK;
                #1;
                chk("async_rst_tick", peri_rdata, 32'h0);
                @(posedge clk);
                #1;
                rst = 1'b1;
                model_reset();
            end
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: a = A_TH;
                1: a = A_TL;
                2: a = A_TCON;
                3: a = A_LED;
                4: a = A_SW;
                5: a = A_DIGI;
                6: a = A_TICK;
                7: a = BASE + 32'h1C;
                8: a = BASE + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(1, 3));
                default: a = $urandom;
            endcase
            w = $urandom;
            if (pick == 1 && $urandom_range(0, 1) == 1) w = 32'hFFFF_FFFF - 32'($urandom_range(0, 12));
            if (pick == 0 && $urandom_range(0, 1) == 1) w = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
            if (pick == 2) w = 32'($urandom_range(0, 7));
            cre = ($urandom_range(0, 3) != 0);
            cwe = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
            cyc(cre, cwe, a, w, rd, erd);
            chk("rand_rdata", rd, erd);
            chk("rand_led", {24'h0, led}, {24'h0, m_led});
            chk("rand_digi", {20'h0, digi}, {20'h0, m_digi});
            chk("rand_irq", {31'h0, irq}, {31'h0, m_tcon[2]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
